// File: rtl/fifo_sc_buffer.sv
// rtl/fifo_sc_buffer.sv - single-clock first-word-fall-through FIFO with programmable flags
//
// Ports:
//   clk           single clock, rising edge
//   global_rst_n  asynchronous active-low reset (assert async, release sync)
//   wr_en, din    write request and data; ignored while full
//   full          no space left
//   prog_full     occupancy >= PROG_FULL_THRESH
//   rd_en         acknowledges the word currently on dout; ignored while empty
//   dout          head-of-queue word, 0 while empty
//   empty         no data held
//   prog_empty    occupancy <= PROG_EMPTY_THRESH
//   data_count    registered occupancy (only with FIFO_DATA_COUNT_EN defined)
//
// Optional feature macro: FIFO_DATA_COUNT_EN

module fifo_sc_buffer #(
    parameter int RD_DATA_WIDTH     = 64,
    parameter int WR_DATA_WIDTH     = 64,
    parameter int RAM_DATA_WIDTH    = 64,
    parameter int WR_DEPTH          = 1024,
    parameter int PROG_FULL_THRESH  = WR_DEPTH - 16,
    parameter int PROG_EMPTY_THRESH = 16
) (
    input  logic                                clk,
    input  logic                                global_rst_n,
    input  logic                                wr_en,
    input  logic [WR_DATA_WIDTH-1:0]            din,
    output logic                                full,
    output logic                                prog_full,
    input  logic                                rd_en,
    output logic [RD_DATA_WIDTH-1:0]            dout,
    output logic                                empty,
    output logic                                prog_empty
`ifdef FIFO_DATA_COUNT_EN
    ,
    output logic [$clog2(WR_DEPTH):0]           data_count
`endif
);

    localparam int AW = $clog2(WR_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(WR_DEPTH);
    localparam logic [CW-1:0] PF_THR  = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] PE_THR  = CW'(PROG_EMPTY_THRESH);

    if (RD_DATA_WIDTH != WR_DATA_WIDTH) begin : g_bad_rd_width
        $error("fifo_sc_buffer: RD_DATA_WIDTH must equal WR_DATA_WIDTH");
    end
    if (RAM_DATA_WIDTH != WR_DATA_WIDTH) begin : g_bad_ram_width
        $error("fifo_sc_buffer: RAM_DATA_WIDTH must equal WR_DATA_WIDTH");
    end
    if ((WR_DEPTH < 16) || ((WR_DEPTH & (WR_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_sc_buffer: WR_DEPTH must be a power of two and >= 16");
    end

    // Reset is applied asynchronously but released on a clock edge so that
    // no pointer or flag flop sees a reset removal close to the active edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [RAM_DATA_WIDTH-1:0] mem [WR_DEPTH];

    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            occ;
    logic [AW-1:0]            wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0]            occ_nxt;
    logic [RD_DATA_WIDTH-1:0] dout_nxt;
    logic                     wr_acc, rd_acc;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_nxt = wr_acc ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_nxt = rd_acc ? rd_ptr + 1'b1 : rd_ptr;
        occ_nxt    = occ;
        case ({wr_acc, rd_acc})
            2'b10:   occ_nxt = occ + 1'b1;
            2'b01:   occ_nxt = occ - 1'b1;
            default: occ_nxt = occ;
        endcase

        // dout is a register holding the next head word. The next head may be
        // the word being written on this same edge (empty FIFO, or the last
        // stored word being read), in which case it comes straight from din.
        if (occ_nxt == '0) begin
            dout_nxt = '0;
        end else if (wr_acc && (rd_ptr_nxt == wr_ptr)) begin
            dout_nxt = din;
        end else begin
            dout_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            dout       <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            prog_empty <= 1'b1;
            prog_full  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            occ        <= occ_nxt;
            dout       <= dout_nxt;
            empty      <= (occ_nxt == '0);
            full       <= (occ_nxt == DEPTH_C);
            prog_empty <= (occ_nxt <= PE_THR);
            prog_full  <= (occ_nxt >= PF_THR);
        end
    end

`ifdef FIFO_DATA_COUNT_EN
    assign data_count = occ;
`endif

endmodule

// File: tb/tb_fifo_sc_buffer.sv
// tb/tb_fifo_sc_buffer.sv - self-checking bench for fifo_sc_buffer

module tb_fifo_sc_buffer;

    localparam int DW    = 64;
    localparam int DEPTH = 1024;
    localparam int PF    = DEPTH - 16;
    localparam int PE    = 16;

    logic          clk = 1'b0;
    logic          global_rst_n;
    logic          wr_en, rd_en;
    logic [DW-1:0] din, dout;
    logic          full, empty, prog_full, prog_empty;
`ifdef FIFO_DATA_COUNT_EN
    logic [$clog2(DEPTH):0] data_count;
`endif

    always #5 clk = ~clk;

    fifo_sc_buffer #(
        .RD_DATA_WIDTH(DW), .WR_DATA_WIDTH(DW), .RAM_DATA_WIDTH(DW), .WR_DEPTH(DEPTH),
        .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE)
    ) dut (
        .clk(clk),
        .global_rst_n(global_rst_n),
        .wr_en(wr_en),
        .din(din),
        .full(full),
        .prog_full(prog_full),
        .rd_en(rd_en),
        .dout(dout),
        .empty(empty),
        .prog_empty(prog_empty)
`ifdef FIFO_DATA_COUNT_EN
        ,
        .data_count(data_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: a plain queue of the words currently held.
    logic [DW-1:0] model_q[$];

    typedef struct {
        logic          we;
        logic          re;
        logic [DW-1:0] d;
        logic          e_empty;
        logic [DW-1:0] e_dout;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, "_empty"}, 64'(empty), 64'(sz == 0));
        check({tag, "_full"}, 64'(full), 64'(sz == DEPTH));
        check({tag, "_prog_full"}, 64'(prog_full), 64'(sz >= PF));
        check({tag, "_prog_empty"}, 64'(prog_empty), 64'(sz <= PE));
        check({tag, "_dout"}, dout, (sz == 0) ? 64'd0 : model_q[0]);
`ifdef FIFO_DATA_COUNT_EN
        check({tag, "_data_count"}, 64'(data_count), 64'(sz));
`endif
    endtask

    // One clock edge with the given inputs; the model applies the same
    // acceptance rules from its own state, then everything is compared.
    task automatic step(input logic we, input logic re, input logic [DW-1:0] d, input string tag);
        bit wa, ra;
        wr_en = we;
        rd_en = re;
        din   = d;
        @(posedge clk);
        wa = we && (model_q.size() < DEPTH);
        ra = re && (model_q.size() > 0);
        if (ra) void'(model_q.pop_front());
        if (wa) model_q.push_back(d);
        #1;
        check_model(tag);
    endtask

    task automatic apply_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        global_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        global_rst_n = 1'b1;
        model_q.delete();
        repeat (3) step(1'b0, 1'b0, '0, "post_reset");
    endtask

    initial begin
        int rcnt, wcnt, cyc;
        logic [DW-1:0] base;

        vt[0] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h0};
        vt[1] = '{1'b1, 1'b0, 64'hA5, 1'b0, 64'hA5};
        vt[2] = '{1'b0, 1'b0, 64'h0,  1'b0, 64'hA5};
        vt[3] = '{1'b0, 1'b1, 64'h0,  1'b1, 64'h0};
        vt[4] = '{1'b0, 1'b1, 64'h0,  1'b1, 64'h0};
        vt[5] = '{1'b1, 1'b1, 64'h11, 1'b0, 64'h11};
        vt[6] = '{1'b1, 1'b0, 64'h22, 1'b0, 64'h11};
        vt[7] = '{1'b1, 1'b1, 64'h33, 1'b0, 64'h22};
        vt[8] = '{1'b0, 1'b1, 64'h0,  1'b0, 64'h33};
        vt[9] = '{1'b0, 1'b1, 64'h0,  1'b1, 64'h0};

        apply_reset();

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, "idle");

        for (int i = 0; i < 10; i++) begin
            step(vt[i].we, vt[i].re, vt[i].d, "vec");
            check("vec_empty_tbl", 64'(empty), 64'(vt[i].e_empty));
            check("vec_dout_tbl", dout, vt[i].e_dout);
        end

        // Fill to full, overflow attempt, simultaneous read/write at full.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, DW'(i), "fill");
            if (i + 1 == PF - 1) check("pf_below", 64'(prog_full), 64'd0);
            if (i + 1 == PF)     check("pf_at", 64'(prog_full), 64'd1);
            if (i + 1 == DEPTH - 1) check("full_before", 64'(full), 64'd0);
        end
        check("full_at_depth", 64'(full), 64'd1);
        step(1'b1, 1'b0, 64'hBAD0_BAD0, "overflow");
        check("overflow_full", 64'(full), 64'd1);
        step(1'b1, 1'b1, 64'hDEAD_BEEF, "both_full");
        check("both_full_full", 64'(full), 64'd0);
        check("both_full_dout", dout, 64'd1);
        for (int k = 1; k < DEPTH; k++) begin
            check("drain_order", dout, DW'(k));
            step(1'b0, 1'b1, '0, "drain");
        end
        check("drain_empty", 64'(empty), 64'd1);

        // Continuous streaming with incrementing data.
        base = 64'h1000_0000;
        rcnt = 0;
        wcnt = 0;
        cyc  = 0;
        while (rcnt < 5000 && cyc < 20000) begin
            logic we, re;
            we = !full && (wcnt < 5000);
            re = !empty;
            if (re) check("stream_order", dout, base + DW'(rcnt));
            step(we, re, base + DW'(wcnt), "stream");
            if (we) wcnt++;
            if (re) rcnt++;
            cyc++;
        end
        check("stream_done", 64'(rcnt), 64'd5000);

        // Random traffic with varying bias so occupancy wanders widely.
        for (int ph = 0; ph < 4; ph++) begin
            int pw;
            pw = (ph % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 2000; i++) begin
                logic we, re;
                we = ($urandom_range(0, 99) < pw);
                re = ($urandom_range(0, 99) < (100 - pw));
                step(we, re, {$urandom, $urandom}, "rand");
            end
        end

        // Reset mid-stream with 300 words queued.
        apply_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, DW'(i + 7), "pre_rst");
        @(posedge clk);
        #3;
        global_rst_n = 1'b0;
        #1;
        check("arst_empty", 64'(empty), 64'd1);
        check("arst_full", 64'(full), 64'd0);
        check("arst_prog_empty", 64'(prog_empty), 64'd1);
        check("arst_prog_full", 64'(prog_full), 64'd0);
        check("arst_dout", dout, 64'd0);
        model_q.delete();
        repeat (2) @(posedge clk);
        #1;
        global_rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, '0, "rst_release");
        step(1'b1, 1'b0, 64'h5A5A, "after_rst_wr");
        check("after_rst_dout", dout, 64'h5A5A);
        step(1'b0, 1'b1, '0, "after_rst_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sc_buffer.md
Name: fifo_sc_buffer

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO with one clock.
- Buffers WR_DEPTH words between a producer and a consumer in the same clock domain.
- Provides full, empty and programmable almost-full/almost-empty flags.
- Interface matches the team's FIFO port set, so it drops into any stream-buffering point.

Parameters:
- RD_DATA_WIDTH, 64: read data width. Must equal WR_DATA_WIDTH; elaboration error otherwise.
- WR_DATA_WIDTH, 64: write data width.
- RAM_DATA_WIDTH, 64: storage word width. Must equal WR_DATA_WIDTH.
- WR_DEPTH, 1024: number of words. Power of two, >= 16.
- PROG_FULL_THRESH, WR_DEPTH-16: occupancy at or above which prog_full asserts.
- PROG_EMPTY_THRESH, 16: occupancy at or below which prog_empty asserts.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- global_rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- din  in  WR_DATA_WIDTH  write data.
- full  out  1  no space; writes ignored.
- prog_full  out  1  occupancy >= PROG_FULL_THRESH.
- rd_en  in  1  read request (acknowledges the word on dout).
- dout  out  RD_DATA_WIDTH  head-of-queue word (FWFT).
- empty  out  1  no data; reads ignored.
- prog_empty  out  1  occupancy <= PROG_EMPTY_THRESH.

Behaviour:
- Reset: asynchronous assert on global_rst_n low, synchronous release. While in reset:
  - write and read pointers = 0, occupancy = 0
  - empty=1, full=0, prog_empty=1, prog_full=0, dout=0
  - storage contents don't care
- Pointers are $clog2(WR_DEPTH) bits and wrap naturally. Occupancy is $clog2(WR_DEPTH)+1 bits, range 0..WR_DEPTH.
- Write accepted at an edge iff wr_en=1 and full=0: din stored at the write pointer, write pointer +1.
- Read accepted at an edge iff rd_en=1 and empty=0: read pointer +1.
- Occupancy update per edge:
  - +1 on write-only
  - -1 on read-only
  - unchanged when both are accepted or neither is
- Flags are registered, derived from next-state occupancy, and valid immediately after the edge:
  - full = (occ==WR_DEPTH)
  - empty = (occ==0)
  - prog_full = (occ>=PROG_FULL_THRESH)
  - prog_empty = (occ<=PROG_EMPTY_THRESH)
- FWFT latency:
  - A word written into an empty FIFO at edge N appears on dout with empty=0 immediately after edge N.
  - dout always shows the oldest unread word while empty=0.
  - After an accepted read, dout shows the next word in the same cycle the pointer advances.
- dout is forced to 0 while empty=1.
- Boundary cases:
  - Full with wr_en and rd_en both high: the read is accepted, the write is dropped, full deasserts.
  - Empty with both high: the write is accepted, the read is ignored, empty deasserts.
  - Write while full and read while empty are silently ignored; no state changes.
- Data order is strictly preserved across pointer wrap-around.
- Reset asserted mid-operation discards all contents and returns to the reset state at once.

Optional Feature:
- Macro FIFO_DATA_COUNT_EN.
- Defined: adds output data_count, width $clog2(WR_DEPTH)+1, equal to the registered occupancy. Reset value 0; updates on the same edge as the flags.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: empty=1, prog_empty=1, full=0, prog_full=0, dout=0 for 10 cycles.
- Single write of 0xA5 at edge N, then rd_en held low:
  - empty=0 and dout=0xA5 after edge N
  - one read → empty=1, dout=0
- Write 1024 incrementing words with rd_en=0:
  - prog_full rises when occupancy reaches 1008, full after the 1024th
  - a 1025th write is ignored
  - draining returns 0..1023 in order
- At full, drive wr_en=1 and rd_en=1 for one edge: occupancy becomes 1023, the dropped word never appears, full=0.
- Continuous streaming (wr_en=~full, rd_en=~empty, incrementing din) for 5000 words:
  - dout equals the read-count reference on every accepted read
  - wrap-around is error-free
- Assert global_rst_n low mid-stream with 300 words queued: flags and dout take reset values asynchronously, and after release the FIFO behaves as empty.
